video_palctl: RTL and testbench

- Palette write controller for the 16-entry, 6-bit video palette; sits between the CPU-side port decoder and the palette RAM write port.
- Queues CPU palette writes and commits them only during blanking, so the visible picture is never torn.
- Runs a default-palette load sequencer after reset and on request.
- Drives the palette's write strobe, write index and write data; the index overrides the pixel/border lookup address while a write is in progress.

---
 rtl/video_pal_defs.sv | 25 ++
 rtl/video_palctl_fifo.sv | 73 +++++++
 rtl/video_palctl.sv | 145 ++++++++++++++
 tb/tb_video_palctl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pal_defs.sv
// Shared definitions for the video palette write controller.
//   PAL_W / IDX_W / ENTRY_W : palette colour width, index width, queued entry width.
//   pal_state_e             : controller states INIT / IDLE / DRAIN.
//   default_colour()        : colour loaded into entry i by the default-palette sequencer.
package video_pal_defs;

    localparam int PAL_W   = 6;
    localparam int IDX_W   = 4;
    localparam int ENTRY_W = IDX_W + PAL_W;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        DRAIN = 2'd2
    } pal_state_e;

    // Index bits: [0]=B, [1]=R, [2]=G, [3]=bright. Colour layout is {g1,g0,r1,r0,b1,b0}.
    // A lit component is full scale when bright, two-thirds otherwise.
    function automatic logic [PAL_W-1:0] default_colour(input logic [IDX_W-1:0] i);
        logic [1:0] lit;
        lit = i[3] ? 2'b11 : 2'b10;
        return {i[2] ? lit : 2'b00, i[1] ? lit : 2'b00, i[0] ? lit : 2'b00};
    endfunction

endpackage

// File: rtl/video_palctl_fifo.sv
// Synchronous first-word-fall-through queue for pending CPU palette writes.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i/data_i : write an entry (ignored when full)
//   pop_i/data_o  : data_o always shows the oldest entry; pop_i retires it (ignored when empty)
//   flush_i       : discard all entries; wins over push and pop in the same cycle
//   full_o/empty_o: occupancy flags from the current (registered) level
//   level_next_o  : occupancy after this cycle's push/pop/flush, for registered status flags
module video_palctl_fifo
    import video_pal_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_next_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_next_o = level_d;

    always_comb begin
        level_d = level_q;
        if (flush_i) begin
            level_d = '0;
        end else if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/video_palctl.sv
// Palette write controller: queues CPU palette writes and commits them to the
// palette RAM write port only while blanking (or immediately when BLANK_ONLY=0),
// and loads the default palette after reset or on init_req.
//   clk, rst              : 28 MHz video clock, asynchronous active-high reset
//   hblank, vblank        : blanking inputs that open the commit window
//   cpu_wr/cpu_idx/cpu_data, cpu_ready : CPU write request and queue-accept flag
//   init_req              : reload the default palette (flushes queued writes)
//   pal_wr/pal_idx/pal_data : palette write port; idx/data hold when pal_wr=0
//   busy                  : default load running or writes still queued
//
// state | meaning
// INIT  | writing default colours to entries 0..15, one per cycle
// IDLE  | queue empty or commit window closed, no write this cycle
// DRAIN | committing queued writes, one per cycle while the window is open
module video_palctl
    import video_pal_defs::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hblank,
    input  logic             vblank,
    input  logic             cpu_wr,
    input  logic [IDX_W-1:0] cpu_idx,
    input  logic [PAL_W-1:0] cpu_data,
    output logic             cpu_ready,
    input  logic             init_req,
    output logic             pal_wr,
    output logic [IDX_W-1:0] pal_idx,
    output logic [PAL_W-1:0] pal_data,
    output logic             busy
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    pal_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             pal_wr_q, pal_wr_d;
    logic [IDX_W-1:0] pal_idx_q, pal_idx_d;
    logic [PAL_W-1:0] pal_data_q, pal_data_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic               commit, push, pop;
    logic [ENTRY_W-1:0] fifo_rd;
    logic               fifo_full, fifo_empty;
    logic [LVL_W-1:0]   level_next;

    assign commit = BLANK_ONLY ? (hblank | vblank) : 1'b1;
    // ready_q already encodes !full && state!=INIT for this cycle, so full is
    // judged before any pop happening alongside the push.
    assign push   = cpu_wr && ready_q && !init_req;
    assign pop    = !init_req && (state_q != INIT) && !fifo_empty && commit;

    video_palctl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push),
        .data_i       ({cpu_idx, cpu_data}),
        .pop_i        (pop),
        .flush_i      (init_req),
        .data_o       (fifo_rd),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .level_next_o (level_next)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pal_wr_d   = 1'b0;
        pal_idx_d  = pal_idx_q;
        pal_data_d = pal_data_q;

        if (init_req) begin
            state_d = INIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    pal_wr_d   = 1'b1;
                    pal_idx_d  = cnt_q;
                    pal_data_d = default_colour(cnt_q);
                    cnt_d      = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(15)) state_d = IDLE;
                end
                IDLE, DRAIN: begin
                    if (pop) begin
                        pal_wr_d   = 1'b1;
                        pal_idx_d  = fifo_rd[ENTRY_W-1:PAL_W];
                        pal_data_d = fifo_rd[PAL_W-1:0];
                        state_d    = (level_next != '0) ? DRAIN : IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            endcase
        end

        // Status flags describe the cycle after this edge, so derive them
        // from next-state values to keep them registered yet current.
        busy_d  = (state_d == INIT) || (level_next != '0);
        ready_d = (state_d != INIT) && (level_next != LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            pal_wr_q   <= 1'b0;
            pal_idx_q  <= '0;
            pal_data_q <= '0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pal_wr_q   <= pal_wr_d;
            pal_idx_q  <= pal_idx_d;
            pal_data_q <= pal_data_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign pal_wr    = pal_wr_q;
    assign pal_idx   = pal_idx_q;
    assign pal_data  = pal_data_q;
    assign busy      = busy_q;
    assign cpu_ready = ready_q;

    // fifo_full is implied by ready_q; kept visible for debug probing.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_video_palctl.sv
module tb_video_palctl;

    localparam int DEPTH = 4;

    typedef struct {
        int         cyc;
        logic [3:0] idx;
        logic [5:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hblank = 1'b0, vblank = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [3:0] cpu_idx = '0;
    logic [5:0] cpu_data = '0;
    logic       init_req = 1'b0;

    // index 0: BLANK_ONLY=1, index 1: BLANK_ONLY=0; both see the same stimulus
    logic       cpu_ready_w [2];
    logic       pal_wr_w    [2];
    logic [3:0] pal_idx_w   [2];
    logic [5:0] pal_data_w  [2];
    logic       busy_w      [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    video_palctl #(.FIFO_DEPTH(DEPTH), .BLANK_ONLY(1'b1)) u_dut_blank (
        .clk(clk), .rst(rst), .hblank(hblank), .vblank(vblank),
        .cpu_wr(cpu_wr), .cpu_idx(cpu_idx), .cpu_data(cpu_data),
        .cpu_ready(cpu_ready_w[0]), .init_req(init_req),
        .pal_wr(pal_wr_w[0]), .pal_idx(pal_idx_w[0]), .pal_data(pal_data_w[0]),
        .busy(busy_w[0])
    );

    video_palctl #(.FIFO_DEPTH(DEPTH), .BLANK_ONLY(1'b0)) u_dut_imm (
        .clk(clk), .rst(rst), .hblank(hblank), .vblank(vblank),
        .cpu_wr(cpu_wr), .cpu_idx(cpu_idx), .cpu_data(cpu_data),
        .cpu_ready(cpu_ready_w[1]), .init_req(init_req),
        .pal_wr(pal_wr_w[1]), .pal_idx(pal_idx_w[1]), .pal_data(pal_data_w[1]),
        .busy(busy_w[1])
    );

    always #18 clk = ~clk;

    // ---------------- reference model ----------------
    int         init_left [2] = '{16, 16};
    logic [9:0] fq        [2][$];
    exp_t       expq      [2][$];
    bit         m_ready   [2] = '{1'b0, 1'b0};
    bit         m_busy    [2] = '{1'b1, 1'b1};
    logic [3:0] last_idx  [2] = '{4'd0, 4'd0};
    logic [5:0] last_data [2] = '{6'd0, 6'd0};

    function automatic logic [5:0] ref_colour(input int i);
        int lvl, g, r, b;
        lvl = (i >= 8) ? 3 : 2;
        g = ((i / 4) % 2 == 1) ? lvl : 0;
        r = ((i / 2) % 2 == 1) ? lvl : 0;
        b = (i % 2 == 1) ? lvl : 0;
        return 6'(g * 16 + r * 4 + b);
    endfunction

    task automatic expect_write(input int k, input logic [3:0] i, input logic [5:0] d);
        exp_t x;
        x.cyc = cyc; x.idx = i; x.data = d;
        expq[k].push_back(x);
        last_idx[k]  = i;
        last_data[k] = d;
    endtask

    always @(posedge clk) begin
        bit         commit, ready_now;
        logic [9:0] e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            commit = (k == 1) || hblank || vblank;
            if (rst) begin
                fq[k].delete();
                init_left[k] = 16;
                m_ready[k] = 1'b0;
                m_busy[k]  = 1'b1;
                last_idx[k]  = '0;
                last_data[k] = '0;
            end else begin
                ready_now = m_ready[k];
                if (init_req) begin
                    fq[k].delete();
                    init_left[k] = 16;
                end else if (init_left[k] > 0) begin
                    expect_write(k, 4'(16 - init_left[k]), ref_colour(16 - init_left[k]));
                    init_left[k]--;
                end else begin
                    if (fq[k].size() > 0 && commit) begin
                        e = fq[k].pop_front();
                        expect_write(k, e[9:6], e[5:0]);
                    end
                    if (cpu_wr && ready_now) fq[k].push_back({cpu_idx, cpu_data});
                end
                m_ready[k] = (init_left[k] == 0) && (fq[k].size() < DEPTH);
                m_busy[k]  = (init_left[k] > 0) || (fq[k].size() > 0);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", name, k, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        bit   want_wr;
        exp_t x;
        for (int k = 0; k < 2; k++) begin
            check("cpu_ready", k, 32'(cpu_ready_w[k]), 32'(m_ready[k]));
            check("busy", k, 32'(busy_w[k]), 32'(m_busy[k]));
            want_wr = (expq[k].size() > 0) && (expq[k][0].cyc == cyc);
            check("pal_wr", k, 32'(pal_wr_w[k]), 32'(want_wr));
            if (want_wr) begin
                x = expq[k].pop_front();
                if (pal_wr_w[k]) begin
                    check("pal_idx", k, 32'(pal_idx_w[k]), 32'(x.idx));
                    check("pal_data", k, 32'(pal_data_w[k]), 32'(x.data));
                end
            end else if (!pal_wr_w[k]) begin
                check("pal_idx_hold", k, 32'(pal_idx_w[k]), 32'(last_idx[k]));
                check("pal_data_hold", k, 32'(pal_data_w[k]), 32'(last_data[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit wr, input logic [3:0] i, input logic [5:0] d,
                        input bit hb, input bit vb, input bit ir);
        @(negedge clk);
        #1;
        cpu_wr = wr; cpu_idx = i; cpu_data = d;
        hblank = hb; vblank = vb; init_req = ir;
    endtask

    task automatic idle(input int n, input bit hb);
        repeat (n) step(1'b0, 4'd0, 6'd0, hb, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        rst = 1'b1;
        cpu_wr = 1'b0; init_req = 1'b0;
        repeat (n) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        bit hb_r;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;

        // default palette load, no blanking
        idle(20, 1'b0);

        // single write held off until blank
        step(1'b1, 4'd5, 6'h2A, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);
        idle(2, 1'b0);

        // fill the queue, fifth write dropped, then drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 6'(i), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);
        idle(2, 1'b0);

        // blank toggles during a 3-entry drain
        for (int i = 0; i < 3; i++) step(1'b1, 4'(10 + i), 6'(6'h30 + i), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        step(1'b0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        idle(2, 1'b0);

        // init_req flushes queued writes
        step(1'b1, 4'd7, 6'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd8, 6'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        idle(20, 1'b1);

        // init_req restarting an in-progress load
        step(1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b0);
        step(1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        idle(20, 1'b0);

        // immediate-commit latency and same-index writes
        step(1'b1, 4'd9, 6'h3F, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd9, 6'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd9, 6'h02, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(4, 1'b1);

        // mid-operation reset with entries queued
        step(1'b1, 4'd3, 6'h15, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd4, 6'h16, 1'b0, 1'b0, 1'b0);
        do_reset(2);
        idle(20, 1'b0);

        // randomized traffic
        hb_r = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) hb_r = ~hb_r;
            if (n == 1200) do_reset(1);
            step($urandom_range(0, 99) < 45, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                 hb_r, $urandom_range(0, 99) < 3, $urandom_range(0, 399) == 0);
        end

        // drain everything and confirm nothing is left outstanding
        idle(40, 1'b1);
        @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            check("outstanding_writes", k, 32'(expq[k].size()), 32'd0);
            check("final_busy", k, 32'(busy_w[k]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
